// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan
// Description : Multiplexed 4-digit seven-segment driver. Snapshots four BCD
//               digits once per refresh frame and scans them onto a shared
//               active-low segment bus with active-low anode selects. Also
//               provides leading-zero blanking and per-digit decimal points.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an,
    output logic        frame_start
);

    // A two-cycle digit period still needs one tick bit.
    localparam int c_TICK_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(DIGIT_CYCLES - 1);
    localparam logic [6:0] c_SEG_OFF = 7'b1111111;

    logic [c_TICK_W-1:0] r_tick;
    logic [1:0]          r_sel;
    logic [15:0]         r_shadow_digits;
    logic [3:0]          r_shadow_dp;
    logic                r_shadow_blz;
    logic                r_valid;
    logic                r_pending;

    logic [6:0]          r_seg;
    logic                r_dp_n;
    logic [3:0]          r_an;
    logic                r_frame_start;

    logic                w_tick_last;
    logic                w_load;
    logic [3:0]          w_nibble;
    logic [3:0]          w_zero;
    logic [3:0]          w_lz;
    logic                w_blank;
    logic [6:0]          w_seg_dec;
    logic [6:0]          w_seg_next;
    logic [3:0]          w_an_next;
    logic                w_dp_n_next;

    assign w_tick_last = (r_tick == c_TICK_LAST);
    // A frame boundary is the last tick of digit 3; an empty shadow loads at once.
    assign w_load      = ~r_valid | (w_tick_last & (r_sel == 2'd3));

    // Digit i is a leading zero when it and every digit above it are zero.
    assign w_zero[0] = (r_shadow_digits[3:0]   == 4'd0);
    assign w_zero[1] = (r_shadow_digits[7:4]   == 4'd0);
    assign w_zero[2] = (r_shadow_digits[11:8]  == 4'd0);
    assign w_zero[3] = (r_shadow_digits[15:12] == 4'd0);
    assign w_lz[3]   = w_zero[3];
    assign w_lz[2]   = w_zero[2] & w_lz[3];
    assign w_lz[1]   = w_zero[1] & w_lz[2];
    assign w_lz[0]   = 1'b0;  // the rightmost digit always shows
    assign w_blank   = r_shadow_blz & w_lz[r_sel];

    // Select the shadow nibble for the digit currently being scanned.
    always_comb begin
        w_nibble = r_shadow_digits[3:0];
        case (r_sel)
            2'd0:    w_nibble = r_shadow_digits[3:0];
            2'd1:    w_nibble = r_shadow_digits[7:4];
            2'd2:    w_nibble = r_shadow_digits[11:8];
            default: w_nibble = r_shadow_digits[15:12];
        endcase
    end

    // BCD to active-low segments (g..a); non-BCD codes show nothing.
    always_comb begin
        w_seg_dec = c_SEG_OFF;
        case (w_nibble)
            4'd0:    w_seg_dec = 7'b1000000;
            4'd1:    w_seg_dec = 7'b1111001;
            4'd2:    w_seg_dec = 7'b0100100;
            4'd3:    w_seg_dec = 7'b0110000;
            4'd4:    w_seg_dec = 7'b0011001;
            4'd5:    w_seg_dec = 7'b0010010;
            4'd6:    w_seg_dec = 7'b0000010;
            4'd7:    w_seg_dec = 7'b1111000;
            4'd8:    w_seg_dec = 7'b0000000;
            4'd9:    w_seg_dec = 7'b0010000;
            default: w_seg_dec = c_SEG_OFF;
        endcase
    end

    // Next output word; everything is dark until the first snapshot exists.
    always_comb begin
        w_seg_next  = c_SEG_OFF;
        w_an_next   = 4'b1111;
        w_dp_n_next = 1'b1;
        if (r_valid) begin
            w_seg_next  = w_blank ? c_SEG_OFF : w_seg_dec;
            w_an_next   = ~(4'b0001 << r_sel);
            w_dp_n_next = ~r_shadow_dp[r_sel];
        end
    end

    // Dwell counter and digit select; held at zero until a snapshot is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= '0;
            r_sel  <= 2'd0;
        end else if (!r_valid) begin
            r_tick <= '0;
            r_sel  <= 2'd0;
        end else if (w_tick_last) begin
            r_tick <= '0;
            r_sel  <= r_sel + 2'd1;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    // Frame snapshot of the inputs; pending marks that digit 0 of it is next out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_digits <= 16'd0;
            r_shadow_dp     <= 4'd0;
            r_shadow_blz    <= 1'b0;
            r_valid         <= 1'b0;
            r_pending       <= 1'b0;
        end else begin
            r_pending <= w_load;
            if (w_load) begin
                r_shadow_digits <= digits;
                r_shadow_dp     <= dp;
                r_shadow_blz    <= blank_lz;
                r_valid         <= 1'b1;
            end
        end
    end

    // All display outputs change together on one edge so no glitch combination appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg         <= c_SEG_OFF;
            r_dp_n        <= 1'b1;
            r_an          <= 4'b1111;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg_next;
            r_dp_n        <= w_dp_n_next;
            r_an          <= w_an_next;
            r_frame_start <= r_pending;
        end
    end

    assign seg         = r_seg;
    assign dp_n        = r_dp_n;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan
// Description : Self-checking bench for seven_seg_scan with a frame-level
//               reference model driven by recorded input history.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

    localparam int c_DC    = 4;
    localparam int c_FRAME = 4 * c_DC;
    localparam int c_DEPTH = 4096;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_start;

    int errors;
    int checks;
    int n;  // edges since reset released (0 = reset edge)

    logic [15:0] h_dig [0:c_DEPTH-1];
    logic [3:0]  h_dp  [0:c_DEPTH-1];
    logic        h_blz [0:c_DEPTH-1];

    seven_seg_scan #(.DIGIT_CYCLES(c_DC)) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp          (dp),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp_n        (dp_n),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [15:0] d, input logic blz, input int pos);
        logic [3:0]  nib;
        logic [15:0] upper;
        nib   = d[4*pos +: 4];
        upper = d >> (4 * pos);
        if (blz && pos > 0 && upper == 16'd0) return 7'b1111111;
        case (nib)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {an, seg, dp_n, frame_start} after edge k since reset release.
    function automatic logic [12:0] model_out(input int k);
        int m, pos, ld;
        logic [3:0] a;
        if (k <= 1) return {4'b1111, 7'b1111111, 1'b1, 1'b0};
        m   = k - 2;
        pos = (m / c_DC) % 4;
        ld  = 1 + (m / c_FRAME) * c_FRAME;
        a   = 4'b1111;
        a[pos] = 1'b0;
        return {a, ref_seg(h_dig[ld], h_blz[ld], pos), ~h_dp[ld][pos], (m % c_FRAME) == 0};
    endfunction

    // One clock edge: record the inputs it samples, then settle past the edge.
    task automatic step();
        int nn;
        nn = rst ? 0 : n + 1;
        if (nn < c_DEPTH) begin
            h_dig[nn] = digits;
            h_dp[nn]  = dp;
            h_blz[nn] = blank_lz;
        end
        @(posedge clk);
        #1;
        n = nn;
    endtask

    task automatic do_reset(input logic [15:0] d, input logic [3:0] p, input logic b);
        digits   = d;
        dp       = p;
        blank_lz = b;
        rst      = 1'b1;
        step();
        step();
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        digits = 16'h1234; dp = 4'd0; blank_lz = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({an, seg, dp_n, frame_start} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_values cyc=%0d got an=%b seg=%b dp_n=%b fs=%b exp 1111/1111111/1/0",
                         i, an, seg, dp_n, frame_start);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (an !== 4'b1111 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_edge1 got an=%b fs=%b exp an=1111 fs=0", an, frame_start);
        end
        step();
        checks++;
        if (an !== 4'b1110 || frame_start !== 1'b1 || seg !== 7'b0011001) begin
            errors++;
            $display("FAIL reset_edge2 got an=%b fs=%b seg=%b exp an=1110 fs=1 seg=0011001",
                     an, frame_start, seg);
        end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [0:3];
        logic [3:0] exp_an  [0:3];
        int pos;
        exp_seg[0] = 7'b0011001; exp_an[0] = 4'b1110;
        exp_seg[1] = 7'b0110000; exp_an[1] = 4'b1101;
        exp_seg[2] = 7'b0100100; exp_an[2] = 4'b1011;
        exp_seg[3] = 7'b1111001; exp_an[3] = 4'b0111;
        do_reset(16'h1234, 4'd0, 1'b0);
        step();
        for (int i = 0; i < 3 * c_FRAME; i++) begin
            step();
            pos = (i / c_DC) % 4;
            checks++;
            if (an !== exp_an[pos] || seg !== exp_seg[pos] || frame_start !== ((i % c_FRAME) == 0)) begin
                errors++;
                $display("FAIL scan_seq i=%0d got an=%b seg=%b fs=%b exp an=%b seg=%b fs=%b",
                         i, an, seg, frame_start, exp_an[pos], exp_seg[pos], (i % c_FRAME) == 0);
            end
        end
    endtask

    task automatic test_snapshot();
        int  guard;
        logic [12:0] exp;
        do_reset(16'h1234, 4'd0, 1'b0);
        guard = 0;
        while (an !== 4'b1101 && guard < 40) begin step(); guard++; end
        checks++;
        if (an !== 4'b1101) begin
            errors++;
            $display("FAIL snapshot_wait_an got an=%b exp 1101 within 40 cycles", an);
        end
        digits = 16'h5678;
        guard = 0;
        do begin
            step();
            guard++;
            exp = model_out(n);
            checks++;
            if ({an, seg, dp_n, frame_start} !== exp) begin
                errors++;
                $display("FAIL snapshot_model n=%0d got %b exp %b", n, {an, seg, dp_n, frame_start}, exp);
            end
        end while (frame_start !== 1'b1 && guard < 40);
        checks++;
        if (frame_start !== 1'b1 || seg !== 7'b0000000 || an !== 4'b1110) begin
            errors++;
            $display("FAIL snapshot_new_frame got fs=%b an=%b seg=%b exp fs=1 an=1110 seg=0000000",
                     frame_start, an, seg);
        end
    endtask

    task automatic test_blanking();
        logic [6:0] want;
        do_reset(16'h0070, 4'd0, 1'b1);
        step();
        for (int i = 0; i < c_FRAME; i++) begin
            step();
            case (an)
                4'b1110: want = 7'b1000000;
                4'b1101: want = 7'b1111000;
                default: want = 7'b1111111;
            endcase
            checks++;
            if (seg !== want) begin
                errors++;
                $display("FAIL blank_0070 an=%b got seg=%b exp %b", an, seg, want);
            end
        end
        do_reset(16'h0000, 4'd0, 1'b1);
        step();
        for (int i = 0; i < c_FRAME; i++) begin
            step();
            want = (an == 4'b1110) ? 7'b1000000 : 7'b1111111;
            checks++;
            if (seg !== want) begin
                errors++;
                $display("FAIL blank_0000 an=%b got seg=%b exp %b", an, seg, want);
            end
        end
    endtask

    task automatic test_invalid_dp();
        do_reset(16'h00A0, 4'b0100, 1'b0);
        step();
        for (int i = 0; i < c_FRAME; i++) begin
            step();
            checks++;
            if (dp_n !== (an != 4'b1011)) begin
                errors++;
                $display("FAIL dp_select an=%b got dp_n=%b exp %b", an, dp_n, an != 4'b1011);
            end
            if (an == 4'b1101) begin
                checks++;
                if (seg !== 7'b1111111) begin
                    errors++;
                    $display("FAIL invalid_bcd got seg=%b exp 1111111", seg);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        int guard;
        do_reset(16'h1234, 4'd0, 1'b0);
        guard = 0;
        while (an !== 4'b1011 && guard < 40) begin step(); guard++; end
        checks++;
        if (an !== 4'b1011) begin
            errors++;
            $display("FAIL midreset_wait_an got an=%b exp 1011 within 40 cycles", an);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values got an=%b seg=%b fs=%b exp 1111/1111111/0", an, seg, frame_start);
        end
        step();
        checks++;
        if (an !== 4'b1111) begin
            errors++;
            $display("FAIL midreset_edge1 got an=%b exp 1111", an);
        end
        step();
        checks++;
        if (an !== 4'b1110 || frame_start !== 1'b1 || seg !== 7'b0011001) begin
            errors++;
            $display("FAIL midreset_restart got an=%b fs=%b seg=%b exp 1110/1/0011001", an, frame_start, seg);
        end
    endtask

    task automatic test_random();
        logic [12:0] exp;
        do_reset(16'($urandom), 4'($urandom), 1'($urandom));
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                // Bias towards small values so leading-zero blanking is exercised.
                if ($urandom_range(0, 1) == 0) digits = 16'($urandom) & 16'h00FF;
                else                           digits = 16'($urandom);
                dp       = 4'($urandom);
                blank_lz = 1'($urandom);
            end
            rst = (i > 10 && $urandom_range(0, 199) == 0);
            step();
            exp = model_out(n);
            checks++;
            if ({an, seg, dp_n, frame_start} !== exp) begin
                errors++;
                $display("FAIL random_model i=%0d n=%0d got %b exp %b", i, n, {an, seg, dp_n, frame_start}, exp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        n        = 0;
        rst      = 1'b1;
        digits   = 16'd0;
        dp       = 4'd0;
        blank_lz = 1'b0;
        test_reset();
        test_scan();
        test_snapshot();
        test_blanking();
        test_invalid_dp();
        test_midframe_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
